// File: rtl/cpu_defs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_defs_pkg : shared fetch-sequencer state encoding and constants |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package cpu_defs_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_HALT  = 2'd3
   } fetch_state_t;

   localparam int unsigned WORD_BYTES       = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Forces an address onto a word boundary by clearing the byte-offset bits.
   function automatic logic [31:0] word_align(input logic [31:0] i_addr);
      return {i_addr[31:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_incr.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_incr : 32-bit combinational PC + 4, carry out discarded         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pc_incr
   import cpu_defs_pkg::*;
(
   input  logic [31:0] i_pc,
   output logic [31:0] o_pc_plus4
);

   assign o_pc_plus4 = i_pc + 32'(WORD_BYTES);

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_sequencer : PC owner, imem handshake and IR hand-off to decode|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_sequencer
   import cpu_defs_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          CNT_W    = 32
)
(
   input  logic             CLK,
   input  logic             RST,
   input  logic             run,
   input  logic             halt_in,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      ir,
   output logic             ir_valid,
   input  logic             retire,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic             halted,
   output logic             align_err,
   output logic [CNT_W-1:0] retired_cnt
);

   fetch_state_t     r_state;
   fetch_state_t     w_state_nxt;

   logic [31:0]      r_pc;
   logic [31:0]      r_ir;
   logic             r_ir_valid;
   logic             r_align_err;
   logic             r_halt_pending;
   logic [CNT_W-1:0] r_cnt;

   logic [31:0]      w_pc_plus4;
   logic [31:0]      w_pc_next;
   logic             w_req;
   logic             w_ir_load;
   logic             w_retire_fire;
   logic             w_set_halt_pending;

   pc_incr u_pc_incr (
      .i_pc       (r_pc),
      .o_pc_plus4 (w_pc_plus4)
   );

   assign w_pc_next = redirect_valid ? word_align(redirect_pc) : w_pc_plus4;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_req              = 1'b0;
      w_ir_load          = 1'b0;
      w_retire_fire      = 1'b0;
      w_set_halt_pending = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (halt_in) begin
               w_state_nxt = ST_HALT;
            end else if (run) begin
               w_state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            // A halt request cannot abort an outstanding read; it is deferred.
            w_req = 1'b1;
            if (halt_in) begin
               w_set_halt_pending = 1'b1;
            end
            if (imem_ack) begin
               w_ir_load   = 1'b1;
               w_state_nxt = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (retire) begin
               w_retire_fire = 1'b1;
               w_state_nxt   = (halt_in || r_halt_pending) ? ST_HALT : ST_FETCH;
            end else if (halt_in) begin
               w_set_halt_pending = 1'b1;
            end
         end
         ST_HALT: begin
            w_state_nxt = ST_HALT;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pc           <= word_align(RESET_PC);
         r_ir           <= 32'h0000_0000;
         r_ir_valid     <= 1'b0;
         r_align_err    <= 1'b0;
         r_halt_pending <= 1'b0;
         r_cnt          <= '0;
      end else begin
         if (w_ir_load) begin
            r_ir       <= imem_rdata;
            r_ir_valid <= 1'b1;
         end
         if (w_retire_fire) begin
            r_ir_valid     <= 1'b0;
            r_cnt          <= r_cnt + CNT_W'(1);
            r_pc           <= w_pc_next;
            r_halt_pending <= 1'b0;
            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
               r_align_err <= 1'b1;
            end
         end else if (w_set_halt_pending) begin
            r_halt_pending <= 1'b1;
         end
      end
   end

   assign imem_req    = w_req;
   assign imem_addr   = r_pc;
   assign ir          = r_ir;
   assign ir_valid    = r_ir_valid;
   assign pc          = r_pc;
   assign pc_plus4    = w_pc_plus4;
   assign halted      = (r_state == ST_HALT);
   assign align_err   = r_align_err;
   assign retired_cnt = r_cnt;

endmodule
`default_nettype wire
